// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Provides the in-flight owner encoding, default widths and address helpers.
package cpu_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 64;

  // Owner of the access currently in flight (issued last cycle).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INF_IF = 2'd1,
    INF_D  = 2'd2
  } owner_e;

  // Byte address to word address; callers truncate to their index width,
  // which makes the index wrap modulo the memory depth.
  function automatic logic [MEM_ADDR_W-1:0] word_idx(input logic [MEM_ADDR_W-1:0] addr);
    return {2'b00, addr[MEM_ADDR_W-1:2]};
  endfunction

  // Any address not on a word boundary.
  function automatic logic misaligned(input logic [MEM_ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rr_fixed_pick.sv
// Two-requester fixed-priority picker with per-requester masks.
// Ports:
//   req_if / req_d   : raw requests
//   mask_if / mask_d : 1 removes that requester from this cycle's pick
//   gnt_if / gnt_d   : one-hot (or zero) grant
// DATA_PRIO=1 lets the data port win a conflict, 0 lets fetch win.
module rr_fixed_pick #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic req_if,
  input  logic req_d,
  input  logic mask_if,
  input  logic mask_d,
  output logic gnt_if,
  output logic gnt_d
);

  logic cand_if_s;
  logic cand_d_s;

  // Grant selection among unmasked requesters.
  always_comb begin
    cand_if_s = req_if & ~mask_if;
    cand_d_s  = req_d & ~mask_d;
    if (cand_if_s && cand_d_s) begin
      gnt_d  = DATA_PRIO;
      gnt_if = ~DATA_PRIO;
    end else begin
      gnt_d  = cand_d_s;
      gnt_if = cand_if_s;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, synchronous-read, word-addressed memory between
// instruction fetch and the data (lw/sw) port.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr                  : fetch request, held until if_valid
//   if_rdata/if_valid/if_err        : fetch response (one-cycle pulse)
//   if_stall                        : fetch stall to pipeline control
//   d_req/d_we/d_addr/d_wdata       : data request, held until d_valid
//   d_rdata/d_valid/d_err           : data response (one-cycle pulse)
//   d_stall                         : data stall to pipeline control
//   mem_en/mem_we/mem_idx/mem_wdata : memory command, combinational from grant
//   mem_rdata                       : memory read data, valid cycle after mem_en
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int DEPTH     = MEM_DEPTH,
  parameter bit DATA_PRIO = 1'b1,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_err,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_err,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_idx,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e            state_r;
  owner_e            state_next_s;
  logic              err_r;
  logic              we_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              gnt_if_s;
  logic              gnt_d_s;
  logic              gnt_any_s;
  logic              sel_mis_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              resp_if_s;
  logic              resp_d_s;

  // A port in its response cycle still presents the old request, so it is
  // masked; reset blocks all grants so nothing (e.g. a store) reaches memory.
  rr_fixed_pick #(
    .DATA_PRIO(DATA_PRIO)
  ) u_pick (
    .req_if (if_req & ~reset),
    .req_d  (d_req & ~reset),
    .mask_if(state_r == INF_IF),
    .mask_d (state_r == INF_D),
    .gnt_if (gnt_if_s),
    .gnt_d  (gnt_d_s)
  );

  // Owner state plus the attributes of the in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      state_r <= state_next_s;
      err_r   <= sel_mis_s;
      we_r    <= gnt_d_s & d_we;
    end
  end

  // Next owner: whoever was granted this cycle, otherwise idle.
  always_comb begin
    state_next_s = IDLE;
    if (gnt_d_s) begin
      state_next_s = INF_D;
    end else if (gnt_if_s) begin
      state_next_s = INF_IF;
    end else begin
      state_next_s = IDLE;
    end
  end

  // Held copies of the last read data per port; stores and errors keep them.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      if (resp_if_s && !err_r) begin
        if_rdata_r <= mem_rdata;
      end
      if (resp_d_s && !err_r && !we_r) begin
        d_rdata_r <= mem_rdata;
      end
    end
  end

  // Memory command, responses and stalls.
  always_comb begin
    gnt_any_s  = gnt_if_s | gnt_d_s;
    sel_addr_s = gnt_d_s ? d_addr : if_addr;
    // A misaligned grant is consumed but never touches memory.
    sel_mis_s  = gnt_any_s & misaligned(sel_addr_s);
    mem_en     = gnt_any_s & ~sel_mis_s;
    mem_we     = gnt_d_s & d_we & ~sel_mis_s;
    mem_idx    = IDX_W'(word_idx(sel_addr_s));
    mem_wdata  = d_wdata;

    // Reset in a response cycle cancels the pulse.
    resp_if_s  = (state_r == INF_IF) & ~reset;
    resp_d_s   = (state_r == INF_D) & ~reset;
    if_valid   = resp_if_s;
    d_valid    = resp_d_s;
    if_err     = resp_if_s & err_r;
    d_err      = resp_d_s & err_r;
    if_rdata   = (resp_if_s && !err_r) ? mem_rdata : if_rdata_r;
    d_rdata    = (resp_d_s && !err_r && !we_r) ? mem_rdata : d_rdata_r;
    if_stall   = if_req & ~if_valid;
    d_stall    = d_req & ~d_valid;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural synchronous memory.
module tb_unified_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_err;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        preload;
  logic [31:0] mem [64];

  int vectors;
  int miscompares;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(64), .DATA_PRIO(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_err(if_err), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model, preloaded on the first reset edge.
  always @(posedge clk) begin
    if (preload) begin
      mem[1] <= 32'h100F0004;
      mem[2] <= 32'h22222222;
      mem[3] <= 32'h33333333;
      mem[4] <= 32'h44444444;
    end else if (mem_en) begin
      if (mem_we) mem[mem_idx] <= mem_wdata;
      else        mem_rdata    <= mem[mem_idx];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mem_rdata   = 32'h0;
    preload     = 1'b1;
    reset       = 1'b1;
    if_req      = 1'b1;
    if_addr     = 32'h04;
    d_req       = 1'b1;
    d_we        = 1'b0;
    d_addr      = 32'h08;
    d_wdata     = 32'h0;

    // Reset held for three edges with both ports requesting.
    cyc(); preload = 1'b0;
    cyc();
    cyc(); #1;
    chk("rst_mem_en",   {31'b0, mem_en},   32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_d_valid",  {31'b0, d_valid},  32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata",  d_rdata,  32'h0);

    // First cycle out of reset: data port wins.
    reset = 1'b0; #1;
    chk("first_mem_en",  {31'b0, mem_en}, 32'h1);
    chk("first_mem_idx", {26'b0, mem_idx}, 32'd2);
    chk("first_mem_we",  {31'b0, mem_we}, 32'h0);
    chk("first_d_stall", {31'b0, d_stall}, 32'h1);

    // Data response; fetch of 0x04 issued while data is masked.
    cyc(); d_req = 1'b0; #1;
    chk("c1_d_valid",  {31'b0, d_valid}, 32'h1);
    chk("c1_d_err",    {31'b0, d_err}, 32'h0);
    chk("c1_d_rdata",  d_rdata, 32'h22222222);
    chk("c1_mem_en",   {31'b0, mem_en}, 32'h1);
    chk("c1_mem_idx",  {26'b0, mem_idx}, 32'd1);
    chk("c1_if_stall", {31'b0, if_stall}, 32'h1);

    // Fetch response.
    cyc(); #1;
    chk("c2_if_valid", {31'b0, if_valid}, 32'h1);
    chk("c2_if_rdata", if_rdata, 32'h100F0004);
    chk("c2_if_stall", {31'b0, if_stall}, 32'h0);
    if_req = 1'b0; #1;
    chk("c2_mem_en",   {31'b0, mem_en}, 32'h0);

    // Simultaneous lw 0x08 and fetch 0x0C, held continuously.
    cyc(); d_req = 1'b1; d_addr = 32'h08; if_req = 1'b1; if_addr = 32'h0C; #1;
    chk("s0_mem_en",   {31'b0, mem_en}, 32'h1);
    chk("s0_mem_idx",  {26'b0, mem_idx}, 32'd2);
    chk("s0_if_stall", {31'b0, if_stall}, 32'h1);
    cyc(); #1;
    chk("s1_d_valid",  {31'b0, d_valid}, 32'h1);
    chk("s1_d_rdata",  d_rdata, 32'h22222222);
    chk("s1_mem_en",   {31'b0, mem_en}, 32'h1);
    chk("s1_mem_idx",  {26'b0, mem_idx}, 32'd3);
    cyc(); #1;
    chk("s2_if_valid", {31'b0, if_valid}, 32'h1);
    chk("s2_if_rdata", if_rdata, 32'h33333333);
    chk("s2_d_valid",  {31'b0, d_valid}, 32'h0);
    chk("s2_mem_en",   {31'b0, mem_en}, 32'h1);
    chk("s2_mem_idx",  {26'b0, mem_idx}, 32'd2);
    cyc(); #1;
    chk("s3_d_valid",  {31'b0, d_valid}, 32'h1);
    chk("s3_mem_en",   {31'b0, mem_en}, 32'h1);
    chk("s3_mem_idx",  {26'b0, mem_idx}, 32'd3);
    cyc(); d_req = 1'b0; if_req = 1'b0; #1;
    chk("s4_if_valid", {31'b0, if_valid}, 32'h1);
    chk("s4_mem_en",   {31'b0, mem_en}, 32'h0);

    // Store 0xDEADBEEF to 0x10.
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; #1;
    chk("st_if_valid", {31'b0, if_valid}, 32'h0);
    chk("st_mem_en",   {31'b0, mem_en}, 32'h1);
    chk("st_mem_we",   {31'b0, mem_we}, 32'h1);
    chk("st_mem_idx",  {26'b0, mem_idx}, 32'd4);
    chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    cyc(); d_we = 1'b0; #1;
    chk("st_d_valid",  {31'b0, d_valid}, 32'h1);
    chk("st_d_rdata_hold", d_rdata, 32'h22222222);
    chk("st_resp_mem_en", {31'b0, mem_en}, 32'h0);
    // Reload the same address.
    cyc(); #1;
    chk("ld_mem_en",   {31'b0, mem_en}, 32'h1);
    chk("ld_mem_we",   {31'b0, mem_we}, 32'h0);
    chk("ld_mem_idx",  {26'b0, mem_idx}, 32'd4);
    cyc(); d_req = 1'b0; #1;
    chk("ld_d_valid",  {31'b0, d_valid}, 32'h1);
    chk("ld_d_rdata",  d_rdata, 32'hDEADBEEF);

    // Misaligned load at 0x06.
    cyc(); d_req = 1'b1; d_addr = 32'h06; #1;
    chk("mis_mem_en",  {31'b0, mem_en}, 32'h0);
    chk("mis_d_stall", {31'b0, d_stall}, 32'h1);
    cyc(); d_req = 1'b0; #1;
    chk("mis_d_valid", {31'b0, d_valid}, 32'h1);
    chk("mis_d_err",   {31'b0, d_err}, 32'h1);
    chk("mis_d_rdata", d_rdata, 32'hDEADBEEF);

    // Fetch at 0x104 wraps to index 1.
    cyc(); if_req = 1'b1; if_addr = 32'h104; #1;
    chk("wrap_d_err",   {31'b0, d_err}, 32'h0);
    chk("wrap_mem_en",  {31'b0, mem_en}, 32'h1);
    chk("wrap_mem_idx", {26'b0, mem_idx}, 32'd1);

    // Reset in the fetch response cycle kills the pulse.
    cyc(); reset = 1'b1; #1;
    chk("rr_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rr_mem_en",   {31'b0, mem_en}, 32'h0);
    cyc(); reset = 1'b0; if_req = 1'b0; #1;
    chk("rr_post_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rr_post_if_rdata", if_rdata, 32'h0);
    chk("rr_post_if_stall", {31'b0, if_stall}, 32'h0);
    cyc(); #1;
    chk("rr_post2_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rr_post2_d_valid",  {31'b0, d_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
